// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared multi-cycle ALU: arbitrates, issues operands,
// waits SETTLE_CYCLES+1 cycles, captures the result and returns it to the winner.
// Optional macro ALU_ARB_ROUND_ROBIN_EN selects round-robin instead of fixed priority.
module alu_arbiter #(
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic       clock_100Mhz,
   input  logic       reset,
   input  logic [1:0] req_valid,
   output logic [1:0] req_ready,
   input  logic [4:0] req_a0,
   input  logic [4:0] req_b0,
   input  logic [1:0] req_mode0,
   input  logic [4:0] req_a1,
   input  logic [4:0] req_b1,
   input  logic [1:0] req_mode1,
   output logic [4:0] alu_A,
   output logic [4:0] alu_B,
   output logic [1:0] alu_mode,
   input  logic [9:0] alu_out,
   input  logic       alu_negative,
   output logic [1:0] rsp_valid,
   input  logic [1:0] rsp_ready,
   output logic [9:0] rsp_data,
   output logic       rsp_negative,
   output logic       busy
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);
   localparam logic [1:0] MODE_SUB    = 2'b10;

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic       grant_q, grant_d;
   logic [4:0] alu_a_q, alu_a_d;
   logic [4:0] alu_b_q, alu_b_d;
   logic [1:0] alu_mode_q, alu_mode_d;
   logic [1:0] rsp_valid_q, rsp_valid_d;
   logic [9:0] rsp_data_q, rsp_data_d;
   logic       rsp_negative_q, rsp_negative_d;
   logic       busy_q, busy_d;
   logic       win_s;
   logic       accept_s;
`ifdef ALU_ARB_ROUND_ROBIN_EN
   logic       last_q, last_d;
`endif

   // Arbitration winner and combinational ready, only offered while idle.
   always_comb begin
      win_s = 1'b0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
      if (req_valid == 2'b11) begin
         win_s = ~last_q;
      end else begin
         win_s = ~req_valid[0];
      end
`else
      win_s = ~req_valid[0];
`endif
      if ((state_q == ST_IDLE) && (req_valid != 2'b00)) begin
         req_ready = win_s ? 2'b10 : 2'b01;
      end else begin
         req_ready = 2'b00;
      end
      accept_s = ((req_valid & req_ready) != 2'b00);
   end

   // Next-state and datapath computation for the single-operation FSM.
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      grant_d        = grant_q;
      alu_a_d        = alu_a_q;
      alu_b_d        = alu_b_q;
      alu_mode_d     = alu_mode_q;
      rsp_valid_d    = rsp_valid_q;
      rsp_data_d     = rsp_data_q;
      rsp_negative_d = rsp_negative_q;
`ifdef ALU_ARB_ROUND_ROBIN_EN
      last_d         = last_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               grant_d    = win_s;
               alu_a_d    = win_s ? req_a1 : req_a0;
               alu_b_d    = win_s ? req_b1 : req_b0;
               alu_mode_d = win_s ? req_mode1 : req_mode0;
               cnt_d      = SETTLE_INIT;
               state_d    = ST_WAIT;
`ifdef ALU_ARB_ROUND_ROBIN_EN
               last_d     = win_s;
`endif
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT: begin
            // Counting down to zero gives SETTLE_CYCLES+1 edges after issue.
            if (cnt_q == 4'd0) begin
               rsp_data_d     = alu_out;
               rsp_negative_d = (alu_mode_q == MODE_SUB) ? alu_negative : 1'b0;
               rsp_valid_d    = grant_q ? 2'b10 : 2'b01;
               state_d        = ST_RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_RESP: begin
            if (rsp_ready[grant_q]) begin
               rsp_valid_d = 2'b00;
               state_d     = ST_IDLE;
            end else begin
               state_d = ST_RESP;
            end
         end
         default: begin
            rsp_valid_d = 2'b00;
            state_d     = ST_IDLE;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers.
   always_ff @(posedge clock_100Mhz or negedge reset) begin
      if (!reset) begin
         state_q        <= ST_IDLE;
         cnt_q          <= 4'd0;
         grant_q        <= 1'b0;
         alu_a_q        <= 5'd0;
         alu_b_q        <= 5'd0;
         alu_mode_q     <= 2'b00;
         rsp_valid_q    <= 2'b00;
         rsp_data_q     <= 10'd0;
         rsp_negative_q <= 1'b0;
         busy_q         <= 1'b0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
         last_q         <= 1'b1;
`endif
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         grant_q        <= grant_d;
         alu_a_q        <= alu_a_d;
         alu_b_q        <= alu_b_d;
         alu_mode_q     <= alu_mode_d;
         rsp_valid_q    <= rsp_valid_d;
         rsp_data_q     <= rsp_data_d;
         rsp_negative_q <= rsp_negative_d;
         busy_q         <= busy_d;
`ifdef ALU_ARB_ROUND_ROBIN_EN
         last_q         <= last_d;
`endif
      end
   end

   assign alu_A        = alu_a_q;
   assign alu_B        = alu_b_q;
   assign alu_mode     = alu_mode_q;
   assign rsp_valid    = rsp_valid_q;
   assign rsp_data     = rsp_data_q;
   assign rsp_negative = rsp_negative_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with a behavioural ALU model.
module tb_alu_arbiter;

   localparam int SETTLE = 2;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] req_valid;
   logic [1:0] req_ready;
   logic [4:0] req_a0, req_b0, req_a1, req_b1;
   logic [1:0] req_mode0, req_mode1;
   logic [4:0] alu_A, alu_B;
   logic [1:0] alu_mode;
   logic [9:0] alu_out;
   logic       alu_negative;
   logic [1:0] rsp_valid;
   logic [1:0] rsp_ready;
   logic [9:0] rsp_data;
   logic       rsp_negative;
   logic       busy;
   logic       force_neg;
   int         n_tests = 0;
   int         n_fail = 0;

   always #5 clk = ~clk;

   alu_arbiter #(.SETTLE_CYCLES(SETTLE)) dut (
      .clock_100Mhz(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a0(req_a0), .req_b0(req_b0), .req_mode0(req_mode0),
      .req_a1(req_a1), .req_b1(req_b1), .req_mode1(req_mode1),
      .alu_A(alu_A), .alu_B(alu_B), .alu_mode(alu_mode),
      .alu_out(alu_out), .alu_negative(alu_negative),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_negative(rsp_negative), .busy(busy)
   );

   // Behavioural ALU; subtract returns magnitude plus a negative flag.
   always_comb begin
      logic [9:0] tmp;
      tmp = {5'd0, alu_A};
      alu_negative = 1'b0;
      case (alu_mode)
         2'b00: alu_out = 10'(alu_A) + 10'(alu_B);
         2'b01: alu_out = 10'(alu_A) * 10'(alu_B);
         2'b10: begin
            if (alu_A >= alu_B) alu_out = 10'(alu_A - alu_B);
            else begin
               alu_out = 10'(alu_B - alu_A);
               alu_negative = 1'b1;
            end
         end
         default: alu_out = tmp << alu_B[3:0];
      endcase
      if (force_neg) alu_negative = 1'b1;
   end

   task automatic do_reset();
      reset = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
   endtask

   // Issue one request, return ready seen before the edge and response latency.
   task automatic run_op(input int idx, input logic [4:0] a, input logic [4:0] b,
                         input logic [1:0] m, output logic [1:0] rdy, output int lat);
      @(negedge clk);
      if (idx == 0) begin
         req_a0 = a; req_b0 = b; req_mode0 = m; req_valid = 2'b01;
      end else begin
         req_a1 = a; req_b1 = b; req_mode1 = m; req_valid = 2'b10;
      end
      #1 rdy = req_ready;
      @(posedge clk);
      #1 req_valid = 2'b00;
      lat = 0;
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk);
         #1;
         if (rsp_valid != 2'b00) begin
            lat = c;
            break;
         end
      end
   endtask

   task automatic handshake(input logic [1:0] rr);
      @(negedge clk);
      rsp_ready = rr;
      @(posedge clk);
      #1 rsp_ready = 2'b00;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      n_tests++;
      if ({req_ready, rsp_valid, rsp_data, rsp_negative, alu_A, alu_B, alu_mode, busy} !== 30'd0) begin
         n_fail++;
         $display("FAIL reset_state: got %h required 0", {req_ready, rsp_valid, rsp_data, rsp_negative, alu_A, alu_B, alu_mode, busy});
      end
   endtask

   task automatic test_add();
      logic [1:0] rdy;
      int lat;
      run_op(0, 5'd7, 5'd5, 2'b00, rdy, lat);
      n_tests++;
      if (rdy !== 2'b01) begin n_fail++; $display("FAIL add_ready: got %b required 01", rdy); end
      n_tests++;
      if (lat !== SETTLE + 1) begin n_fail++; $display("FAIL add_latency: got %0d required %0d", lat, SETTLE + 1); end
      n_tests++;
      if ({rsp_valid, rsp_data, rsp_negative} !== {2'b01, 10'd12, 1'b0}) begin
         n_fail++;
         $display("FAIL add_rsp: got valid=%b data=%0d neg=%b required 01/12/0", rsp_valid, rsp_data, rsp_negative);
      end
      handshake(2'b01);
      n_tests++;
      if ({busy, rsp_valid} !== 3'b000) begin n_fail++; $display("FAIL add_release: got busy=%b valid=%b required 0/00", busy, rsp_valid); end
   endtask

   task automatic test_subtract();
      logic [1:0] rdy;
      int lat;
      run_op(1, 5'd3, 5'd9, 2'b10, rdy, lat);
      n_tests++;
      if ({rdy, rsp_valid, rsp_data, rsp_negative} !== {2'b10, 2'b10, 10'd6, 1'b1}) begin
         n_fail++;
         $display("FAIL sub_rsp: got rdy=%b valid=%b data=%0d neg=%b required 10/10/6/1", rdy, rsp_valid, rsp_data, rsp_negative);
      end
      handshake(2'b10);
      force_neg = 1'b1;
      run_op(1, 5'd3, 5'd9, 2'b00, rdy, lat);
      n_tests++;
      if ({rsp_valid, rsp_data, rsp_negative} !== {2'b10, 10'd12, 1'b0}) begin
         n_fail++;
         $display("FAIL add_neg_forced: got valid=%b data=%0d neg=%b required 10/12/0", rsp_valid, rsp_data, rsp_negative);
      end
      handshake(2'b10);
      force_neg = 1'b0;
      run_op(0, 5'd3, 5'd2, 2'b11, rdy, lat);
      n_tests++;
      if ({rsp_valid, rsp_data} !== {2'b01, 10'd12}) begin
         n_fail++;
         $display("FAIL shift_rsp: got valid=%b data=%0d required 01/12", rsp_valid, rsp_data);
      end
      handshake(2'b01);
   endtask

   task automatic test_withdraw();
      @(negedge clk);
      req_valid = 2'b01;
      #2 req_valid = 2'b00;
      @(posedge clk);
      #1;
      n_tests++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL withdraw: got busy=%b required 0", busy); end
   endtask

   task automatic test_hold();
      logic [1:0] rdy;
      int lat;
      run_op(1, 5'd4, 5'd1, 2'b10, rdy, lat);
      @(negedge clk);
      req_valid = 2'b11;
      rsp_ready = 2'b01;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         n_tests++;
         if ({rsp_valid, rsp_data, rsp_negative, req_ready, busy, alu_A} !== {2'b10, 10'd3, 1'b0, 2'b00, 1'b1, 5'd4}) begin
            n_fail++;
            $display("FAIL hold_cycle%0d: got valid=%b data=%0d neg=%b rdy=%b busy=%b A=%0d required 10/3/0/00/1/4",
                     i, rsp_valid, rsp_data, rsp_negative, req_ready, busy, alu_A);
         end
      end
      @(negedge clk);
      rsp_ready = 2'b10;
      @(posedge clk);
      #1;
      req_valid = 2'b00;
      rsp_ready = 2'b00;
      n_tests++;
      if ({busy, rsp_valid, alu_A} !== {1'b0, 2'b00, 5'd4}) begin
         n_fail++;
         $display("FAIL hold_release: got busy=%b valid=%b A=%0d required 0/00/4", busy, rsp_valid, alu_A);
      end
   endtask

   task automatic test_back_to_back();
      int exp_grant[4];
      int got;
`ifdef ALU_ARB_ROUND_ROBIN_EN
      exp_grant = '{0, 1, 0, 1};
`else
      exp_grant = '{0, 0, 0, 0};
`endif
      do_reset();
      @(negedge clk);
      req_a0 = 5'd1; req_b0 = 5'd1; req_mode0 = 2'b00;
      req_a1 = 5'd2; req_b1 = 5'd2; req_mode1 = 2'b00;
      req_valid = 2'b11;
      for (int k = 0; k < 4; k++) begin
         got = -1;
         for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (rsp_valid != 2'b00) begin
               got = (rsp_valid == 2'b10) ? 1 : 0;
               break;
            end
         end
         n_tests++;
         if (got !== exp_grant[k] || rsp_data !== ((got == 1) ? 10'd4 : 10'd2)) begin
            n_fail++;
            $display("FAIL b2b_grant%0d: got grant=%0d data=%0d required grant=%0d", k, got, rsp_data, exp_grant[k]);
         end
         handshake(2'b11);
      end
      req_valid = 2'b00;
   endtask

   task automatic test_reset_in_flight();
      logic [1:0] rdy;
      int lat;
      @(negedge clk);
      req_a0 = 5'd1; req_b0 = 5'd2; req_mode0 = 2'b00; req_valid = 2'b01;
      @(posedge clk);
      #1 req_valid = 2'b00;
      @(posedge clk);
      #1 reset = 1'b0;
      #1;
      n_tests++;
      if ({busy, rsp_valid, alu_A, alu_B} !== 13'd0) begin
         n_fail++;
         $display("FAIL reset_wait: got busy=%b valid=%b A=%0d B=%0d required 0", busy, rsp_valid, alu_A, alu_B);
      end
      @(negedge clk);
      reset = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      n_tests++;
      if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL no_stale: got valid=%b required 00", rsp_valid); end
      run_op(0, 5'd31, 5'd31, 2'b01, rdy, lat);
      n_tests++;
      if (lat !== SETTLE + 1 || {rsp_valid, rsp_data} !== {2'b01, 10'd961}) begin
         n_fail++;
         $display("FAIL mul_after_reset: got lat=%0d valid=%b data=%0d required %0d/01/961", lat, rsp_valid, rsp_data, SETTLE + 1);
      end
      handshake(2'b01);
   endtask

   initial begin
      reset = 1'b0; req_valid = 2'b00; rsp_ready = 2'b00; force_neg = 1'b0;
      req_a0 = 5'd0; req_b0 = 5'd0; req_mode0 = 2'b00;
      req_a1 = 5'd0; req_b1 = 5'd0; req_mode1 = 2'b00;
      test_reset();
      test_add();
      test_subtract();
      test_withdraw();
      test_hold();
      test_back_to_back();
      test_reset_in_flight();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
